// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Receives a little-endian byte stream (16-bit word count N, then 4*N data
// bytes), assembles 32-bit words and writes them to the instruction memory
// at byte addresses 0, 4, 8, ... The CPU is held in reset until the whole
// image has been written.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_data/in_valid  stream byte and its valid qualifier
//   in_ready          loader accepts a byte this cycle (registered)
//   mem_we            one-cycle write strobe to the instruction memory
//   mem_addr          byte address of the write (word index * 4)
//   mem_wdata         assembled word {b3,b2,b1,b0}
//   cpu_hold          keeps the CPU in reset while 1
//   done              image fully written, sticky until reset
//   overflow          header count exceeded DEPTH, sticky until reset
module imem_loader #(
  parameter int DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  state_t      next_state;

  logic [7:0]  len_lo;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] byte_buf;

  logic        accept;
  logic [15:0] hdr_n;
  logic        last_byte;
  logic        last_word;
  logic        in_range;

  // Next-cycle values of the registered outputs.
  logic        in_ready_d;
  logic        mem_we_d;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_wdata_d;
  logic        done_d;
  logic        overflow_d;

  assign accept    = in_valid & in_ready;
  assign hdr_n     = {in_data, len_lo};
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_idx == (word_cnt - 16'd1));
  assign in_range  = ({1'b0, word_idx} < DEPTH_W);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LEN0;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      LEN0:    if (accept) next_state = LEN1;
      LEN1:    if (accept) next_state = (hdr_n == 16'd0) ? DONE : DATA;
      DATA:    if (accept && last_byte && last_word) next_state = FLUSH;
      FLUSH:   next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = LEN0;
    endcase
  end

  // Output logic. in_ready is derived from the next state so the registered
  // copy always matches the state the loader is in during that cycle.
  // done is raised one edge after entering FLUSH or DONE, so the final write
  // strobe is retired before the CPU is released.
  always_comb begin
    in_ready_d  = (next_state == LEN0) || (next_state == LEN1) || (next_state == DATA);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    done_d      = done || (state == FLUSH) || (state == DONE);
    overflow_d  = overflow;
    if (state == LEN1 && accept && ({1'b0, hdr_n} > DEPTH_W)) begin
      overflow_d = 1'b1;
    end
    // Words past the end of memory are consumed but never written.
    if (state == DATA && accept && last_byte && in_range) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = {14'b0, word_idx, 2'b00};
      mem_wdata_d = {in_data, byte_buf};
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      done      <= done_d;
      cpu_hold  <= ~done_d;
      overflow  <= overflow_d;
    end
  end

  // Header capture and word assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo   <= 8'd0;
      word_cnt <= 16'd0;
      word_idx <= 16'd0;
      byte_idx <= 2'd0;
      byte_buf <= 24'd0;
    end else if (accept) begin
      case (state)
        LEN0: len_lo <= in_data;
        LEN1: begin
          word_cnt <= hdr_n;
          word_idx <= 16'd0;
          byte_idx <= 2'd0;
        end
        DATA: begin
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    byte_buf[7:0]   <= in_data;
            2'd1:    byte_buf[15:8]  <= in_data;
            2'd2:    byte_buf[23:16] <= in_data;
            default: word_idx        <= word_idx + 16'd1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int pulse_err = 0;
  logic prev_we = 1'b0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  imem_loader #(.DEPTH(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: records every strobe and flags strobes wider than a cycle.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      if (prev_we) pulse_err++;
    end
    prev_we = rst_n && mem_we;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dn;
    logic        hold;
    logic        ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wq_addr.delete();
    wq_data.delete();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic r;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      r = in_ready;
      tick();
      n++;
    end while (!r && n < 50);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept byte=%h", b);
    end
    in_valid = 1'b0;
  endtask

  // Idle cycles; a write strobe never belongs in one of these.
  task automatic gap(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      chk("gap_no_we", {31'b0, mem_we}, 32'd0);
    end
  endtask

  task automatic send_word_gaps(input logic [31:0] w, input int idx);
    for (int i = 0; i < 4; i++) begin
      gap($urandom_range(0, 3));
      send_byte(w[8*i +: 8]);
    end
    chk("gap_word_we", {31'b0, mem_we}, 32'd1);
    chk("gap_word_addr", mem_addr, 32'(idx * 4));
    chk("gap_word_data", mem_wdata, w);
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    chk({tag, "_ready"}, {31'b0, in_ready}, {31'b0, e.rdy});
    chk({tag, "_we"},    {31'b0, mem_we},   {31'b0, e.we});
    chk({tag, "_addr"},  mem_addr,          e.addr);
    chk({tag, "_wdata"}, mem_wdata,         e.wdata);
    chk({tag, "_done"},  {31'b0, done},     {31'b0, e.dn});
    chk({tag, "_hold"},  {31'b0, cpu_hold}, {31'b0, e.hold});
    chk({tag, "_ovf"},   {31'b0, overflow}, {31'b0, e.ovf});
  endtask

  logic [31:0] gw[3];
  logic [31:0] w;
  vec_t rst_exp;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Single word, back-to-back, followed by ignored post-done bytes.
    //            v     d      rdy   we    addr   wdata         dn    hold  ovf
    tbl[0] = '{1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h78, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h56, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h34, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h12, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'hAA, 1'b0, 1'b0, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'hFF, 1'b0, 1'b0, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b0};
    rst_exp = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};

    do_reset();
    check_outputs("reset", rst_exp);
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      tick();
      check_outputs($sformatf("vec%0d", i), tbl[i]);
    end
    in_valid = 1'b0;
    chk("single_nwrites", 32'(wq_addr.size()), 32'd1);

    // Three words with random valid gaps.
    gw[0] = 32'h11223344;
    gw[1] = 32'hDEADBEEF;
    gw[2] = 32'h0BADF00D;
    do_reset();
    gap($urandom_range(0, 3));
    send_byte(8'h03);
    gap($urandom_range(0, 3));
    send_byte(8'h00);
    for (int k = 0; k < 3; k++) send_word_gaps(gw[k], k);
    chk("gaps_hold_pre", {31'b0, cpu_hold}, 32'd1);
    tick();
    chk("gaps_done", {31'b0, done}, 32'd1);
    chk("gaps_hold", {31'b0, cpu_hold}, 32'd0);
    chk("gaps_nwrites", 32'(wq_addr.size()), 32'd3);
    for (int k = 0; k < 3 && k < wq_addr.size(); k++) begin
      chk("gaps_q_addr", wq_addr[k], 32'(k * 4));
      chk("gaps_q_data", wq_data[k], gw[k]);
    end

    // Empty image.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    chk("empty_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("empty_done", {31'b0, done}, 32'd1);
    chk("empty_hold", {31'b0, cpu_hold}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h5C;
    tick();
    tick();
    in_valid = 1'b0;
    chk("empty_ready_after", {31'b0, in_ready}, 32'd0);
    chk("empty_done_after", {31'b0, done}, 32'd1);
    chk("empty_nwrites", 32'(wq_addr.size()), 32'd0);
    chk("empty_ovf", {31'b0, overflow}, 32'd0);

    // Overflow: N=130, DEPTH=128.
    do_reset();
    send_byte(8'h82);
    chk("ovf_before_hdr", {31'b0, overflow}, 32'd0);
    send_byte(8'h00);
    chk("ovf_after_hdr", {31'b0, overflow}, 32'd1);
    for (int k = 0; k < 130; k++) begin
      w = {8'hC3, 8'h5A, 16'(k)};
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    end
    chk("ovf_last_we", {31'b0, mem_we}, 32'd0);
    chk("ovf_last_ready", {31'b0, in_ready}, 32'd0);
    chk("ovf_done_pre", {31'b0, done}, 32'd0);
    tick();
    chk("ovf_done", {31'b0, done}, 32'd1);
    chk("ovf_hold", {31'b0, cpu_hold}, 32'd0);
    chk("ovf_nwrites", 32'(wq_addr.size()), 32'd128);
    if (wq_addr.size() == 128) chk("ovf_last_addr", wq_addr[127], 32'h1FC);
    for (int k = 0; k < wq_addr.size(); k++) begin
      chk("ovf_q_addr", wq_addr[k], 32'(k * 4));
      chk("ovf_q_data", wq_data[k], {8'hC3, 8'h5A, 16'(k)});
    end

    // Reset in the middle of word 1.
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    w = 32'hCAFE0001;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    send_byte(8'h99);
    send_byte(8'h88);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_hold", {31'b0, cpu_hold}, 32'd1);
    chk("midrst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    tick();
    chk("midrst_nwrites", 32'(wq_addr.size()), 32'd1);
    rst_n = 1'b1;
    wq_addr.delete();
    wq_data.delete();
    tick();
    chk("midrst_hold_after", {31'b0, cpu_hold}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    w = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    chk("fresh_we", {31'b0, mem_we}, 32'd1);
    chk("fresh_addr", mem_addr, 32'h0);
    chk("fresh_data", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("fresh_done", {31'b0, done}, 32'd1);
    chk("fresh_nwrites", 32'(wq_addr.size()), 32'd1);

    chk("we_pulse_width", 32'(pulse_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
